// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the queued UART transmitter.
package uart_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int         OVERSAMPLE_DEF  = 16;
  localparam logic [9:0] BAUD_9600_50MHZ = 10'd325;

  // A divisor of zero would never tick; run it as divide-by-one instead.
  function automatic logic [9:0] baud_div(input logic [9:0] b);
    return (b == 10'd0) ? 10'd1 : b;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte queue feeding the transmitter; show-ahead read port.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  // Full/empty come from the registered level, so a same-cycle pop never frees a slot early.
  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_queued.sv
// Queued UART transmitter: 8N1 framing, back-to-back frames from a byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_queued
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic [9:0] baudselect,
  input  logic       tx_complete_del_flag,
  output logic       TXD,
  output logic       tx_busy,
  output logic       tx_complete_flag,
  output logic       tx_full,
  output logic       tx_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);

  logic [7:0]    w_rdata;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_level;
  logic          w_bit_end;
  logic          w_load;

  logic [2:0]    r_state;
  logic [9:0]    r_baud;
  logic [9:0]    r_div;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_flag;
  logic          r_ovf;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_start),
    .wdata (tx_data),
    .pop   (w_load),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  assign w_bit_end = (r_div == r_baud - 10'd1) && (r_tick == TW'(OVERSAMPLE - 1));
  // A new frame starts from IDLE or straight out of a finishing stop bit.
  assign w_load    = !w_empty && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

  assign TXD              = r_txd;
  assign tx_busy          = (r_state != ST_IDLE) || (w_level != '0);
  assign tx_complete_flag = r_flag;
  assign tx_full          = w_full;
  assign tx_overflow      = r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_baud  <= 10'd1;
      r_div   <= '0;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_flag  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (tx_start && w_full) r_ovf <= 1'b1;

      if ((r_state == ST_STOP) && w_bit_end) r_flag <= 1'b1;
      else if (tx_complete_del_flag)         r_flag <= 1'b0;

      // Line driver follows the state one cycle later; every bit keeps its full width.
      case (r_state)
        ST_START:  r_txd <= 1'b0;
        ST_DATA:   r_txd <= r_shift[0];
`ifdef UART_TX_PARITY_EN
        ST_PARITY: r_txd <= r_par;
`endif
        default:   r_txd <= 1'b1;
      endcase

      if (w_load) begin
        r_state <= ST_START;
        r_baud  <= baud_div(baudselect);
        r_div   <= '0;
        r_tick  <= '0;
        r_bit   <= '0;
        r_shift <= w_rdata;
`ifdef UART_TX_PARITY_EN
        r_par   <= ^w_rdata;
`endif
      end else if (r_state != ST_IDLE) begin
        if (r_div == r_baud - 10'd1) begin
          r_div  <= '0;
          r_tick <= (r_tick == TW'(OVERSAMPLE - 1)) ? '0 : r_tick + 1'b1;
        end else begin
          r_div  <= r_div + 10'd1;
        end

        if (w_bit_end) begin
          case (r_state)
            ST_START: begin
              r_state <= ST_DATA;
              r_bit   <= '0;
            end
            ST_DATA: begin
              r_shift <= {1'b0, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: r_state <= ST_STOP;
`endif
            default:   r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_queued.sv
// Randomized scoreboard bench for uart_tx_queued: a cycle-level occupancy model
// predicts frames and flags; a serial monitor decodes TXD and checks each frame.
module tb_uart_tx_queued;
  localparam int DEPTH = 4;
  localparam int OS    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic [9:0] baudselect = 10'd2;
  logic       del = 1'b0;
  logic       TXD, tx_busy, tx_complete_flag, tx_full, tx_overflow;

  uart_tx_queued #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS)) dut (
    .clk                  (clk),
    .reset                (reset),
    .tx_data              (tx_data),
    .tx_start             (tx_start),
    .baudselect           (baudselect),
    .tx_complete_del_flag (del),
    .TXD                  (TXD),
    .tx_busy              (tx_busy),
    .tx_complete_flag     (tx_complete_flag),
    .tx_full              (tx_full),
    .tx_overflow          (tx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; int bl; int st; } exp_t;
  exp_t       sb[$];
  logic [7:0] m_q[$];
  bit         m_act, m_flag, m_ovf;
  int         m_left, cyc, gen;
  int         checks, errors;
  bit         chk_en, mon_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: queue occupancy and frame timing from plain arithmetic.
  initial begin
    int qn, bl;
    bit acc, fend;
    logic [7:0] d;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_q.delete(); sb.delete();
        m_act = 0; m_left = 0; m_flag = 0; m_ovf = 0;
        gen++;
      end else begin
        qn   = m_q.size();
        acc  = tx_start && (qn < DEPTH);
        fend = m_act && (m_left == 1);
        if (tx_start && !acc) m_ovf = 1;
        if (fend) m_flag = 1;
        else if (del) m_flag = 0;
        if (m_act) begin
          m_left--;
          if (m_left == 0) m_act = 0;
        end
        if (!m_act && qn > 0) begin
          d = m_q.pop_front();
          bl = OS * ((baudselect == 10'd0) ? 1 : int'(baudselect));
          m_act = 1;
          m_left = NB * bl;
          sb.push_back('{d, bl, cyc + 1});
        end
        if (acc) m_q.push_back(tx_data);
      end
    end
  end

  // Status outputs against the model, every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("tx_busy", tx_busy, m_act || (m_q.size() != 0));
        chk("tx_complete_flag", tx_complete_flag, m_flag);
        chk("tx_full", tx_full, m_q.size() == DEPTH);
        chk("tx_overflow", tx_overflow, m_ovf);
        if (!m_act) chk("txd_idle", TXD, 1);
      end
    end
  end

  // Serial monitor: decode each frame mid-bit and compare with the scoreboard.
  initial begin
    exp_t e;
    int g, off, k;
    logic [10:0] got, exp;
    forever begin
      @(negedge clk);
      if (chk_en && !reset && TXD === 1'b0) begin
        mon_busy = 1;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start cycle %0d: got start bit expected idle line", cyc);
          k = 0;
          while (TXD === 1'b0 && k < 2000) begin @(negedge clk); k++; end
        end else begin
          e = sb.pop_front();
          g = gen;
          chk("start_cycle", cyc, e.st);
          got = '0; exp = '0;
          exp[8:1] = e.d;
`ifdef UART_TX_PARITY_EN
          exp[9] = ^e.d;
`endif
          exp[NB-1] = 1'b1;
          off = 0;
          for (int i = 0; i < NB; i++) begin
            while (off < i * e.bl + e.bl / 2 && gen == g) begin @(negedge clk); off++; end
            got[i] = TXD;
          end
          while (off < NB * e.bl - 1 && gen == g) begin @(negedge clk); off++; end
          if (gen == g) chk("frame", got, exp);
        end
        mon_busy = 0;
      end
    end
  end

  task automatic cyc_in(input bit s, input logic [7:0] d, input bit dl);
    tx_start = s; tx_data = d; del = dl;
    @(negedge clk);
    tx_start = 0; del = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_in(0, 8'h00, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_act || m_q.size() != 0 || sb.size() != 0 || mon_busy) && n < 20000) begin
      cyc_in(0, 8'h00, 0);
      n++;
    end
    chk("drain_in_time", n < 20000, 1);
    idle(3);
  endtask

  initial begin
    int n;
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_txd", TXD, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_flag", tx_complete_flag, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_ovf", tx_overflow, 0);
    reset = 0;
    idle(2);

    // single byte
    cyc_in(1, 8'hA5, 0);
    wait_idle();

    // burst while busy: 4 accepted, 5th dropped
    cyc_in(1, 8'h10, 0);
    idle(3);
    for (int i = 1; i <= 5; i++) cyc_in(1, 8'(i), 0);
    wait_idle();

    // delete on the same cycle the flag sets, then alone
    cyc_in(0, 8'h00, 1);
    cyc_in(1, 8'h5A, 0);
    n = 0;
    while (!(m_act && m_left == 1) && n < 5000) begin cyc_in(0, 8'h00, 0); n++; end
    cyc_in(0, 8'h00, 1);
    idle(5);
    cyc_in(0, 8'h00, 1);
    idle(2);

    // reset mid-DATA with two queued
    cyc_in(1, 8'hFF, 0);
    cyc_in(1, 8'h11, 0);
    cyc_in(1, 8'h22, 0);
    idle(120);
    reset = 1;
    @(negedge clk);
    reset = 0;
    idle(800);

    // baudselect 0, then a mid-frame divisor change
    baudselect = 10'd0;
    cyc_in(1, 8'h07, 0);
    wait_idle();
    baudselect = 10'd2;
    cyc_in(1, 8'h3C, 0);
    cyc_in(1, 8'hC3, 0);
    idle(100);
    baudselect = 10'd3;
    wait_idle();

    // random traffic
    for (int it = 0; it < 25; it++) begin
      baudselect = 10'($urandom_range(0, 2));
      n = $urandom_range(1, 6);
      for (int w = 0; w < n; w++) begin
        cyc_in(1, 8'($urandom), 0);
        repeat ($urandom_range(0, 2)) cyc_in(0, 8'h00, ($urandom_range(0, 7) == 0));
      end
      repeat ($urandom_range(0, 300)) cyc_in(0, 8'h00, ($urandom_range(0, 63) == 0));
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
